// File: rtl/deskew_rx.sv
// Multi-lane deskew: per-lane circular buffers aligned on alignment-marker blocks.
// Optional ALIGN timeout enabled by defining DESKEW_RX_TIMEOUT_EN.
module deskew_rx #(
   parameter int unsigned LANE_N         = 4,
   parameter int unsigned BLOCK_W        = 66,
   parameter int unsigned MAX_SKEW_BIT_N = 1856
) (
   input  logic                        clk,
   input  logic                        nreset,
   input  logic [LANE_N-1:0]           valid_i,
   input  logic [LANE_N-1:0]           am_slip_v_i,
   input  logic [LANE_N-1:0]           am_lock_v_i,
   input  logic [LANE_N*BLOCK_W-1:0]   data_i,
   output logic [LANE_N*BLOCK_W-1:0]   data_o
);

   localparam int unsigned MAX_SKEW_BLOCK_N = (MAX_SKEW_BIT_N - BLOCK_W - 1) / BLOCK_W;
   localparam int unsigned D                = MAX_SKEW_BLOCK_N + 1;
   localparam int unsigned PTR_W            = (D > 1) ? $clog2(D) : 1;

   typedef enum logic [1:0] {StWait, StAlign, StLocked} state_e;

   state_e                         state_q, state_d;
   logic [LANE_N-1:0]              mark_q, mark_d;
   logic [LANE_N-1:0][PTR_W-1:0]   wptr_q, wptr_d;
   logic [LANE_N-1:0][PTR_W-1:0]   rptr_q, rptr_d;
   logic [BLOCK_W-1:0]             mem_q [LANE_N][D];
   logic                           all_valid;

`ifdef DESKEW_RX_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(MAX_SKEW_BLOCK_N + 2);
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(D - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign all_valid = &valid_i;

   // Buffer storage is not reset; only pointers and flags are.
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(LANE_N); i++) begin
         if (valid_i[i]) begin
            mem_q[i][wptr_q[i]] <= data_i[i*BLOCK_W +: BLOCK_W];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      mark_d  = mark_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      data_o  = '0;
`ifdef DESKEW_RX_TIMEOUT_EN
      cnt_d   = '0;
`endif

      for (int i = 0; i < int'(LANE_N); i++) begin
         if (valid_i[i]) begin
            wptr_d[i] = ptr_inc(wptr_q[i]);
         end
      end

      if (|am_slip_v_i) begin
         mark_d  = '0;
         rptr_d  = '0;
         state_d = StWait;
      end else if (state_q == StLocked) begin
         if (all_valid) begin
            for (int i = 0; i < int'(LANE_N); i++) begin
               rptr_d[i] = ptr_inc(rptr_q[i]);
            end
         end
      end else begin
         // Latch the marker block address; a marked lane ignores later markers.
         for (int i = 0; i < int'(LANE_N); i++) begin
            if (valid_i[i] && am_lock_v_i[i] && !mark_q[i]) begin
               mark_d[i] = 1'b1;
               rptr_d[i] = wptr_q[i];
            end
         end
         if (&mark_d) begin
            state_d = StLocked;
         end else if (|mark_d) begin
            state_d = StAlign;
         end
`ifdef DESKEW_RX_TIMEOUT_EN
         if (state_q == StAlign && !(&mark_d)) begin
            cnt_d = cnt_q;
            if (all_valid) begin
               if (cnt_q == CNT_W'(MAX_SKEW_BLOCK_N)) begin
                  mark_d  = '0;
                  rptr_d  = '0;
                  cnt_d   = '0;
                  state_d = StWait;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
`endif
      end

      if (state_q == StLocked) begin
         for (int i = 0; i < int'(LANE_N); i++) begin
            data_o[i*BLOCK_W +: BLOCK_W] = mem_q[i][rptr_q[i]];
         end
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= StWait;
         mark_q  <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
`ifdef DESKEW_RX_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         mark_q  <= mark_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
`ifdef DESKEW_RX_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_deskew_rx.sv
// Directed self-checking bench for deskew_rx (default parameters).
// Timeout vectors follow DESKEW_RX_TIMEOUT_EN, matching the DUT build.
module tb_deskew_rx;

   localparam int LN = 4;
   localparam int BW = 66;
   localparam int W  = LN * BW;

   logic          clk;
   logic          nreset;
   logic [LN-1:0] valid_i;
   logic [LN-1:0] am_slip_v_i;
   logic [LN-1:0] am_lock_v_i;
   logic [W-1:0]  data_i;
   logic [W-1:0]  data_o;

   int n_cmp;
   int n_err;
   int t;

   deskew_rx dut (
      .clk         (clk),
      .nreset      (nreset),
      .valid_i     (valid_i),
      .am_slip_v_i (am_slip_v_i),
      .am_lock_v_i (am_lock_v_i),
      .data_i      (data_i),
      .data_o      (data_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Block contents encode lane and the cycle it was presented.
   function automatic logic [BW-1:0] blk(input int lane, input int cyc);
      return {2'b10, 16'hC0DE, 16'(lane), 32'(cyc)};
   endfunction

   function automatic logic [W-1:0] vec4(input int t0, input int t1, input int t2,
                                        input int t3);
      logic [W-1:0] v;
      v[0*BW +: BW] = blk(0, t0);
      v[1*BW +: BW] = blk(1, t1);
      v[2*BW +: BW] = blk(2, t2);
      v[3*BW +: BW] = blk(3, t3);
      return v;
   endfunction

   task automatic check_eq(input string tag, input logic [W-1:0] got,
                           input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Present one cycle of inputs, then step to just after the rising edge.
   task automatic drive(input logic [LN-1:0] v, input logic [LN-1:0] l,
                        input logic [LN-1:0] s);
      valid_i     = v;
      am_lock_v_i = l;
      am_slip_v_i = s;
      for (int i = 0; i < LN; i++) data_i[i*BW +: BW] = blk(i, t);
      @(posedge clk);
      #1;
      t++;
   endtask

   initial begin
      int base, s, p, q, r, t0, lm, m;
      n_cmp       = 0;
      n_err       = 0;
      t           = 0;
      nreset      = 1'b0;
      valid_i     = '0;
      am_slip_v_i = '0;
      am_lock_v_i = '0;
      data_i      = '0;
      #3;
      check_eq("reset", data_o, '0);
      @(posedge clk);
      #1;
      nreset = 1'b1;
      check_eq("idle", data_o, '0);

      // Staggered markers: skew of one block per lane.
      base = t;
      drive(4'hF, 4'h1, 4'h0);
      check_eq("align_l0", data_o, '0);
      drive(4'hF, 4'h2, 4'h0);
      check_eq("align_l1", data_o, '0);
      drive(4'hF, 4'h4, 4'h0);
      check_eq("align_l2", data_o, '0);
      drive(4'hF, 4'h8, 4'h0);
      check_eq("skew_lock", data_o, vec4(base, base + 1, base + 2, base + 3));
      for (int k = 1; k <= 30; k++) begin
         drive(4'hF, 4'h0, 4'h0);
         check_eq("skew_stream", data_o, vec4(base + k, base + 1 + k, base + 2 + k, base + 3 + k));
      end
      drive(4'h7, 4'h0, 4'h0);
      check_eq("hold_partial", data_o, vec4(base + 30, base + 31, base + 32, base + 33));

      // Slip on lane 2 while locked.
      drive(4'hF, 4'h0, 4'h4);
      check_eq("slip_wait", data_o, '0);
      drive(4'hF, 4'h0, 4'h0);
      check_eq("slip_stay", data_o, '0);

      // All markers together: WAIT straight to LOCKED.
      s = t;
      drive(4'hF, 4'hF, 4'h0);
      check_eq("simul_lock", data_o, vec4(s, s, s, s));
      drive(4'hF, 4'h0, 4'h0);
      check_eq("simul_next", data_o, vec4(s + 1, s + 1, s + 1, s + 1));

      // Slip and marker on the same lane: slip wins, lane 0 stays unmarked.
      drive(4'hF, 4'h0, 4'hF);
      check_eq("slip_all", data_o, '0);
      drive(4'hF, 4'h1, 4'h1);
      check_eq("slip_prio", data_o, '0);
      p = t;
      drive(4'hF, 4'hE, 4'h0);
      check_eq("lanes123", data_o, '0);
      for (int k = 0; k < 3; k++) begin
         drive(4'hF, 4'h0, 4'h0);
         check_eq("no_lock", data_o, '0);
      end
      q = t;
      drive(4'hF, 4'h1, 4'h0);
      check_eq("late_lane0", data_o, vec4(q, p, p, p));

      // Asynchronous reset while locked, then while aligning.
      nreset = 1'b0;
      #1;
      check_eq("rst_locked", data_o, '0);
      @(posedge clk);
      #1;
      nreset = 1'b1;
      drive(4'hF, 4'h7, 4'h0);
      check_eq("pre_rst_align", data_o, '0);
      nreset = 1'b0;
      #1;
      check_eq("rst_align", data_o, '0);
      @(posedge clk);
      #1;
      nreset = 1'b1;
      drive(4'hF, 4'h8, 4'h0);
      check_eq("rst_discard", data_o, '0);
      r = t;
      drive(4'hF, 4'h7, 4'h0);
      check_eq("rst_relock", data_o, vec4(r, r, r, r - 1));

      // Largest tolerated skew: 26 idle cycles between markers.
      drive(4'hF, 4'h0, 4'hF);
      t0 = t;
      drive(4'hF, 4'h1, 4'h0);
      for (int k = 0; k < 26; k++) drive(4'hF, 4'h0, 4'h0);
      lm = t;
      drive(4'hF, 4'hE, 4'h0);
      check_eq("skew27", data_o, vec4(t0, lm, lm, lm));

      // Lane 0 marks, others withheld 28 cycles.
      drive(4'hF, 4'h0, 4'hF);
      t0 = t;
      drive(4'hF, 4'h1, 4'h0);
      for (int k = 0; k < 28; k++) drive(4'hF, 4'h0, 4'h0);
      lm = t;
      drive(4'hF, 4'hE, 4'h0);
`ifdef DESKEW_RX_TIMEOUT_EN
      check_eq("timeout_wait", data_o, '0);
      m = t;
      drive(4'hF, 4'h1, 4'h0);
      check_eq("timeout_relock", data_o, vec4(m, lm, lm, lm));
`else
      // Without the timeout, lane 0's marker slot has been overwritten by t0+28.
      m = t0 + 28;
      check_eq("no_timeout", data_o, vec4(m, lm, lm, lm));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
